vect_divide: RTL and testbench
==============================

# vect_divide

Sequential signed element-wise divider for N-element vectors. It is the inverse companion of the vector Booth multiplier: it takes a vector of products-width dividends and a vector of element-width divisors, and returns per-element quotient, remainder and divide-by-zero flags. It uses a single shared radix-2 restoring divider core that is time-multiplexed across elements under a start/busy/done handshake. It sits downstream of the vector multiply path wherever results must be scaled back to element width.

## Interface
- N, 4, number of vector elements (≥1)
- M, 4, divisor/element width in bits (≥2); dividend and quotient width is 2*M
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a_flat  input  N*2*M  signed dividends; element i is at [i*2M +: 2M]
- b_flat  input  N*M  signed divisors; element i is at [i*M +: M]
- busy  output  1  high from the accepting edge until DONE
- done  output  1  one-cycle pulse when all N results are valid
- q_flat  output  N*2*M  signed quotients, same packing as a_flat
- r_flat  output  N*M  signed remainders, same packing as b_flat
- dz  output  N  per-element divide-by-zero flag

## Operation
- **Reset:** state=IDLE; busy, done, q_flat, r_flat, dz all 0; internal registers 0. Reset asserted mid-operation aborts immediately and no partial results are kept.
- **Start:** start=1 in IDLE latches a_flat/b_flat into internal registers, clears idx to 0, and enters LOAD. Inputs may change freely afterwards. start is ignored in every other state, including DONE.
- **States:** IDLE → LOAD → ITER (2M cycles) → FIX → (idx==N-1 ? DONE : LOAD with idx+1) → IDLE.
- **LOAD:** takes the magnitudes |a[idx]| (2M-bit unsigned) and |b[idx]| (M-bit unsigned), and records sign_q = sa^sb and sign_r = sa. It then clears the partial remainder (M+1 bits) and loads the quotient shift register with |a|.
- **ITER:** one bit per cycle, MSB first. Shift {rem, qsh} left by 1, trial-subtract |b|, and keep the difference with qbit=1 if it is non-negative; otherwise restore with qbit=0.
- **FIX:** writes q[idx] = sign_q ? -qmag : qmag, truncated to 2M bits. Writes r[idx] = sign_r ? -rmag : rmag, truncated to M bits.
- **Rounding:** the quotient truncates toward zero, and the remainder takes the dividend's sign. The identity a = q*b + r holds for every nonzero b.
- **Divide by zero (b[idx]==0):** dz[idx]=1, q[idx] = all ones (-1), r[idx] = a[idx][M-1:0]. The element still takes its full 2M+2 cycles.
- **Overflow:** -2^(2M-1) / -1 wraps to q = -2^(2M-1), r = 0, with no flag.
- **Output holding:** q_flat, r_flat and dz update only in FIX for the current idx. They hold until the next FIX, so elements above idx show the previous run's values while busy.

## Timing
- Start is accepted at edge E0.
- Element i occupies LOAD after edge E0+i(2M+2), ITER for the next 2M cycles, then FIX.
- Each element takes 2M+2 cycles.
- DONE is the cycle after edge E0+N(2M+2). For N=4, M=4 this is edge E0+40.
- done=1 and busy=0 during the DONE cycle. State is IDLE on the next edge, so a back-to-back start is accepted one cycle after done.
- busy=1 from edge E0 until edge E0+N(2M+2).
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package vect_pkg provides:
  - state enum (IDLE, LOAD, ITER, FIX, DONE)
  - width helpers DW=2*M and RW=M+1
  - a function for element slice offsets
  - the DZ quotient constant
- Sub-module div_core implements one-element sequential restoring division:
  - inputs: load, iterate, operand magnitudes
  - outputs: qmag, rmag
- vect_divide owns the FSM, idx counter, iteration counter, operand latches, sign fix-up and output registers.

## Test plan
- N=4, M=4, a={7,-7,7,127}, b={2,2,-2,-8}:
  - q = {8'h03, 8'hFD, 8'hFD, 8'hF1}
  - r = {4'h1, 4'hF, 4'h1, 4'h7}
  - dz = 0
  - done at E0+40
- a[0]=100, b[0]=0 → dz[0]=1, q[0]=8'hFF, r[0]=4'h4; other elements unaffected.
- a[1]=-128, b[1]=-1 → q[1]=8'h80, r[1]=0, dz[1]=0.
- Assert start repeatedly while busy, and change a_flat/b_flat after E0 → no restart; results match the operands latched at E0.
- Assert rst at E0+15 → all outputs 0 and state IDLE in the same cycle. A new start afterwards completes normally in 40 cycles.
- Random signed operands over 1000 runs → q*b+r == a and |r| < |b| for every b≠0; done pulses exactly once per run.

Source files
------------

// File: rtl/vect_divide_pkg.sv
// Shared types and width helpers for the vector divider.
package vect_pkg;

    // Top-level sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Quotient returned for a zero divisor: all ones (-1), sliced to width
    localparam logic [63:0] DZ_QUOT_ALL = '1;

    // Dividend / quotient width for an element width m
    function automatic int dw(input int m);
        return 2 * m;
    endfunction

    // Partial remainder width: one guard bit above the divisor
    function automatic int rw(input int m);
        return m + 1;
    endfunction

    // Bit offset of element idx in a packed vector of width-bit elements
    function automatic int elem_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vect_divide_if.sv
// Request/result bundle between a vector-divide client and the divider.
interface vect_divide_if
    import vect_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4
);
    logic                  start;
    logic [N*dw(M)-1:0]    a_flat;
    logic [N*M-1:0]        b_flat;
    logic                  busy;
    logic                  done;
    logic [N*dw(M)-1:0]    q_flat;
    logic [N*M-1:0]        r_flat;
    logic [N-1:0]          dz;

    modport master (
        output start, a_flat, b_flat,
        input  busy, done, q_flat, r_flat, dz
    );

    modport slave (
        input  start, a_flat, b_flat,
        output busy, done, q_flat, r_flat, dz
    );
endinterface

// File: rtl/vect_divide_div_core.sv
// One-element radix-2 restoring divider working on unsigned magnitudes.
// The quotient shift register starts holding the dividend; each step shifts
// one dividend bit into the partial remainder and one quotient bit in.
module div_core
    import vect_pkg::*;
#(
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             iter_i,
    input  logic [2*M-1:0]   a_mag_i,
    input  logic [M-1:0]     b_mag_i,
    output logic [2*M-1:0]   qmag_o,
    output logic [M-1:0]     rmag_o
);
    localparam int DW = dw(M);
    localparam int RW = rw(M);

    logic [RW-1:0] rem_q, rem_d;
    logic [DW-1:0] qsh_q, qsh_d;
    logic [M-1:0]  div_q;
    logic [RW:0]   shifted;
    logic [RW:0]   trial;
    logic          qbit;

    // Shift-in, trial subtract, keep the difference when it is non-negative
    always_comb begin
        shifted = {rem_q, qsh_q[DW-1]};
        trial   = shifted - {2'b00, div_q};
        qbit    = ~trial[RW];
        rem_d   = qbit ? trial[RW-1:0] : shifted[RW-1:0];
        qsh_d   = {qsh_q[DW-2:0], qbit};
    end

    // Operand load and per-cycle iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            qsh_q <= '0;
            div_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            qsh_q <= a_mag_i;
            div_q <= b_mag_i;
        end else if (iter_i) begin
            rem_q <= rem_d;
            qsh_q <= qsh_d;
        end
    end

    // A restored remainder is always below the divisor, so M bits suffice
    assign qmag_o = qsh_q;
    assign rmag_o = rem_q[M-1:0];

endmodule

// File: rtl/vect_divide.sv
// Signed element-wise vector divider: one shared restoring core walks the
// N elements in turn; quotient truncates toward zero, remainder follows
// the dividend's sign, zero divisors are flagged per element.
module vect_divide
    import vect_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic          clk,
    input  logic          rst,
    vect_divide_if.slave  bus
);
    localparam int DW = dw(M);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DW);

    state_e            state_q, state_d;
    logic [N*DW-1:0]   a_q;
    logic [N*M-1:0]    b_q;
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     cnt_q;
    logic              sign_q_q;
    logic              sign_r_q;
    logic              bzero_q;
    logic              busy_q;
    logic              done_q;

    logic [DW-1:0]     a_sel, a_mag, qmag, q_fix;
    logic [M-1:0]      b_sel, b_mag, rmag, r_fix;
    logic              last_elem;
    logic              iter_last;

    // Current element operands, their magnitudes and the signed fix-up
    always_comb begin
        a_sel     = a_q[elem_off(int'(idx_q), DW) +: DW];
        b_sel     = b_q[elem_off(int'(idx_q), M) +: M];
        a_mag     = a_sel[DW-1] ? (~a_sel + 1'b1) : a_sel;
        b_mag     = b_sel[M-1]  ? (~b_sel + 1'b1) : b_sel;
        q_fix     = bzero_q ? DZ_QUOT_ALL[DW-1:0]
                            : (sign_q_q ? (~qmag + 1'b1) : qmag);
        r_fix     = bzero_q ? a_sel[M-1:0]
                            : (sign_r_q ? (~rmag + 1'b1) : rmag);
        last_elem = (idx_q == IW'(N - 1));
        iter_last = (cnt_q == CW'(DW - 1));
    end

    div_core #(.M(M)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == LOAD),
        .iter_i  (state_q == ITER),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .qmag_o  (qmag),
        .rmag_o  (rmag)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Sequencer next state: one LOAD/ITER/FIX pass per element
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = ITER;
            ITER:    if (iter_last) state_d = FIX;
            FIX:     state_d = last_elem ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latches, counters, sign bookkeeping and handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            bzero_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a_flat;
                        b_q    <= bus.b_flat;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    sign_q_q <= a_sel[DW-1] ^ b_sel[M-1];
                    sign_r_q <= a_sel[DW-1];
                    bzero_q  <= (b_sel == '0);
                    cnt_q    <= '0;
                end
                ITER: cnt_q <= cnt_q + 1'b1;
                FIX: begin
                    if (last_elem) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-element result registers, written only in their own FIX cycle
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        logic [DW-1:0] q_elem_q;
        logic [M-1:0]  r_elem_q;
        logic          dz_elem_q;

        // Capture this element's fixed-up result
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_elem_q  <= '0;
                r_elem_q  <= '0;
                dz_elem_q <= 1'b0;
            end else if (state_q == FIX && idx_q == IW'(gi)) begin
                q_elem_q  <= q_fix;
                r_elem_q  <= r_fix;
                dz_elem_q <= bzero_q;
            end
        end

        assign bus.q_flat[elem_off(gi, DW) +: DW] = q_elem_q;
        assign bus.r_flat[elem_off(gi, M) +: M]   = r_elem_q;
        assign bus.dz[gi]                         = dz_elem_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_vect_divide.sv
// Bench for vect_divide: directed vectors, zero divisor and overflow,
// start-while-busy, mid-run reset, back-to-back and random runs.
module tb_vect_divide;
    localparam int N   = 4;
    localparam int M   = 4;
    localparam int DW  = 2 * M;
    localparam int LAT = N * (DW + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vect_divide_if #(.N(N), .M(M)) bus ();
    vect_divide #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: signed integer division with truncation toward zero
    function automatic void model(input logic [N*DW-1:0] a, input logic [N*M-1:0] b,
                                  output logic [N*DW-1:0] qe, output logic [N*M-1:0] re,
                                  output logic [N-1:0] ze);
        logic [DW-1:0] ae;
        logic [M-1:0]  be;
        int ai, bi;
        qe = '0; re = '0; ze = '0;
        for (int i = 0; i < N; i++) begin
            ae = a[i*DW +: DW];
            be = b[i*M +: M];
            ai = int'($signed(ae));
            bi = int'($signed(be));
            if (bi == 0) begin
                ze[i] = 1'b1;
                qe[i*DW +: DW] = '1;
                re[i*M +: M] = ae[M-1:0];
            end else begin
                ze[i] = 1'b0;
                qe[i*DW +: DW] = DW'(ai / bi);
                re[i*M +: M] = M'(ai % bi);
            end
        end
    endfunction

    // Issue one request; report accept cycle, done cycle and latency (-1 on timeout)
    task automatic do_run(input logic [N*DW-1:0] a, input logic [N*M-1:0] b, input bit hold,
                          output int lat, output int e0, output int dcyc);
        @(negedge clk);
        bus.a_flat = a;
        bus.b_flat = b;
        bus.start  = 1'b1;
        e0 = -1; lat = -1; dcyc = -1;
        for (int k = 0; k < 6 && e0 < 0; k++) begin
            @(posedge clk); #1;
            if (bus.busy) e0 = cyc;
        end
        if (!hold) bus.start = 1'b0;
        if (e0 >= 0) begin
            for (int k = 0; k < 4 * LAT && lat < 0; k++) begin
                @(negedge clk);
                if (hold) begin
                    bus.a_flat = {$urandom, $urandom};
                    bus.b_flat = $urandom;
                end
                @(posedge clk); #1;
                if (bus.done) begin
                    lat  = cyc - e0;
                    dcyc = cyc;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a_flat = '0; bus.b_flat = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.q_flat !== '0) begin failures++; $display("FAIL reset_q got %h want 0", bus.q_flat); end
        checks++; if (bus.r_flat !== '0) begin failures++; $display("FAIL reset_r got %h want 0", bus.r_flat); end
        checks++; if (bus.dz !== '0) begin failures++; $display("FAIL reset_dz got %b want 0", bus.dz); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_vectors();
        logic [N*DW-1:0] a; logic [N*M-1:0] b;
        int lat, e0, dc;
        a = {8'h7F, 8'h07, 8'hF9, 8'h07};
        b = {4'h8, 4'hE, 4'h2, 4'h2};
        do_run(a, b, 1'b0, lat, e0, dc);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL vec_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL vec_busy_in_done got %b want 0", bus.busy); end
        checks++; if (bus.q_flat !== {8'hF1, 8'hFD, 8'hFD, 8'h03}) begin failures++; $display("FAIL vec_q got %h want f1fdfd03", bus.q_flat); end
        checks++; if (bus.r_flat !== {4'h7, 4'h1, 4'hF, 4'h1}) begin failures++; $display("FAIL vec_r got %h want 71f1", bus.r_flat); end
        checks++; if (bus.dz !== 4'b0000) begin failures++; $display("FAIL vec_dz got %b want 0000", bus.dz); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL vec_done_pulse got %b want 0", bus.done); end
        $display("vectors: a=%h b=%h q=%h r=%h lat=%0d", a, b, bus.q_flat, bus.r_flat, lat);
    endtask

    task automatic test_dz_overflow();
        logic [N*DW-1:0] a, qe; logic [N*M-1:0] b, re; logic [N-1:0] ze;
        int lat, e0, dc;
        a = {8'd5, 8'd9, 8'h80, 8'd100};
        b = {4'd3, 4'd2, 4'hF, 4'h0};
        model(a, b, qe, re, ze);
        do_run(a, b, 1'b0, lat, e0, dc);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL dz_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.dz !== 4'b0001) begin failures++; $display("FAIL dz_flags got %b want 0001", bus.dz); end
        checks++; if (bus.q_flat[7:0] !== 8'hFF || bus.r_flat[3:0] !== 4'h4) begin failures++; $display("FAIL dz_elem0 got q=%h r=%h want q=ff r=4", bus.q_flat[7:0], bus.r_flat[3:0]); end
        checks++; if (bus.q_flat[15:8] !== 8'h80 || bus.r_flat[7:4] !== 4'h0) begin failures++; $display("FAIL ovf_elem1 got q=%h r=%h want q=80 r=0", bus.q_flat[15:8], bus.r_flat[7:4]); end
        checks++; if (bus.q_flat !== qe || bus.r_flat !== re) begin failures++; $display("FAIL dz_model got q=%h r=%h want q=%h r=%h", bus.q_flat, bus.r_flat, qe, re); end
        $display("dz/overflow: q=%h r=%h dz=%b", bus.q_flat, bus.r_flat, bus.dz);
    endtask

    task automatic test_ignore_start();
        logic [N*DW-1:0] a, qe; logic [N*M-1:0] b, re; logic [N-1:0] ze;
        int lat, e0, dc;
        a = {8'hC3, 8'h55, 8'h81, 8'h3A};
        b = {4'h5, 4'hB, 4'h3, 4'h9};
        model(a, b, qe, re, ze);
        do_run(a, b, 1'b1, lat, e0, dc);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL hold_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.q_flat !== qe || bus.r_flat !== re || bus.dz !== ze) begin failures++; $display("FAIL hold_results got q=%h r=%h dz=%b want q=%h r=%h dz=%b", bus.q_flat, bus.r_flat, bus.dz, qe, re, ze); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_no_restart got busy=%b want 0", bus.busy); end
        $display("start-while-busy: q=%h r=%h lat=%0d", bus.q_flat, bus.r_flat, lat);
    endtask

    task automatic test_mid_reset();
        logic [N*DW-1:0] a, qe; logic [N*M-1:0] b, re; logic [N-1:0] ze;
        int lat, e0, dc;
        bit seen;
        @(negedge clk);
        bus.a_flat = {8'h11, 8'h22, 8'h33, 8'h44};
        bus.b_flat = {4'h3, 4'h5, 4'h7, 4'h6};
        bus.start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus.busy) seen = 1'b1;
        end
        bus.start = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL rst_accept got busy=0 want 1"); end
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL rst_mid_flags got %b want 00", {bus.busy, bus.done}); end
        checks++; if (bus.q_flat !== '0 || bus.r_flat !== '0 || bus.dz !== '0) begin failures++; $display("FAIL rst_mid_outputs got q=%h r=%h dz=%b want 0", bus.q_flat, bus.r_flat, bus.dz); end
        @(negedge clk);
        rst = 1'b0;
        a = {8'hEC, 8'h64, 8'h9C, 8'h0F};
        b = {4'h3, 4'hD, 4'h7, 4'h4};
        model(a, b, qe, re, ze);
        do_run(a, b, 1'b0, lat, e0, dc);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rst_rerun_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus.q_flat !== qe || bus.r_flat !== re || bus.dz !== ze) begin failures++; $display("FAIL rst_rerun_results got q=%h r=%h want q=%h r=%h", bus.q_flat, bus.r_flat, qe, re); end
        $display("mid-run reset: rerun q=%h r=%h lat=%0d", bus.q_flat, bus.r_flat, lat);
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] a, qe; logic [N*M-1:0] b, re; logic [N-1:0] ze;
        int lat1, e01, dc1, lat2, e02, dc2;
        do_run({8'h40, 8'hBF, 8'h01, 8'hFE}, {4'h7, 4'h2, 4'hF, 4'hC}, 1'b0, lat1, e01, dc1);
        a = {8'h7E, 8'h83, 8'h20, 8'hD0};
        b = {4'hA, 4'h6, 4'h0, 4'h3};
        model(a, b, qe, re, ze);
        do_run(a, b, 1'b0, lat2, e02, dc2);
        checks++; if (e02 !== dc1 + 2) begin failures++; $display("FAIL b2b_accept got cycle %0d want %0d", e02, dc1 + 2); end
        checks++; if (lat2 !== LAT) begin failures++; $display("FAIL b2b_latency got %0d want %0d", lat2, LAT); end
        checks++; if (bus.q_flat !== qe || bus.r_flat !== re || bus.dz !== ze) begin failures++; $display("FAIL b2b_results got q=%h r=%h dz=%b want q=%h r=%h dz=%b", bus.q_flat, bus.r_flat, bus.dz, qe, re, ze); end
        $display("back-to-back: first done %0d second accept %0d", dc1, e02);
    endtask

    task automatic test_random();
        logic [N*DW-1:0] a, qe; logic [N*M-1:0] b, re; logic [N-1:0] ze;
        logic [DW-1:0] as, qs; logic [M-1:0] bs, rs;
        int lat, e0, dc, ai, bi, qi, ri;
        for (int run = 0; run < 1000; run++) begin
            a = {$urandom, $urandom};
            b = $urandom;
            model(a, b, qe, re, ze);
            do_run(a, b, 1'b0, lat, e0, dc);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd_latency run %0d got %0d want %0d", run, lat, LAT); end
            checks++; if (bus.q_flat !== qe || bus.r_flat !== re || bus.dz !== ze) begin failures++; $display("FAIL rnd_model run %0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b", run, bus.q_flat, bus.r_flat, bus.dz, qe, re, ze); end
            for (int i = 0; i < N; i++) begin
                as = a[i*DW +: DW]; bs = b[i*M +: M];
                qs = bus.q_flat[i*DW +: DW]; rs = bus.r_flat[i*M +: M];
                ai = int'($signed(as)); bi = int'($signed(bs));
                qi = int'($signed(qs)); ri = int'($signed(rs));
                if (bi != 0) begin
                    checks++; if (DW'(qi * bi + ri) !== as) begin failures++; $display("FAIL rnd_identity run %0d elem %0d got q=%0d r=%0d want q*b+r=%0d (b=%0d)", run, i, qi, ri, ai, bi); end
                    checks++; if (!((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))) begin failures++; $display("FAIL rnd_rem_bound run %0d elem %0d got r=%0d want |r|<|%0d|", run, i, ri, bi); end
                end
            end
            @(posedge clk); #1;
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rnd_done_once run %0d got done=%b want 0", run, bus.done); end
            $display("run %0d a=%h b=%h q=%h r=%h dz=%b lat=%0d", run, a, b, bus.q_flat, bus.r_flat, bus.dz, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_dz_overflow();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
